// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared control-unit, opcode and loader state definitions
package prog_loader_pkg;

    typedef enum logic [1:0] {
        Init,
        Fetch,
        Decode,
        Execute
    } State;

    typedef enum logic [3:0] {
        _noop   = 4'd0,
        _load_b = 4'd1,
        _load_a = 4'd2,
        _add    = 4'd3,
        _sub    = 4'd4,
        _halt   = 4'd5
    } inst;

    typedef enum logic [2:0] {
        L_IDLE,
        L_HI,
        L_LO,
        L_WRITE,
        L_DONE,
        L_ERR
    } LoadState;

    function automatic string loadstate_to_string(input LoadState s);
        return s == L_IDLE  ? "L_IDLE"  :
               s == L_HI    ? "L_HI"    :
               s == L_LO    ? "L_LO"    :
               s == L_WRITE ? "L_WRITE" :
               s == L_DONE  ? "L_DONE"  :
               s == L_ERR   ? "L_ERR"   : "L_UNKNOWN";
    endfunction

endpackage

// File: rtl/loader_addr_counter.sv
// loader_addr_counter: instruction-memory write address and session word count
module loader_addr_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              inc_len,
    input  logic              inc_addr,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W:0]   len,
    output logic              at_last
);

    assign at_last = &addr;

    // Address advances only when another word will follow; length counts every write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr <= '0;
            len  <= '0;
        end else if (clear) begin
            addr <= '0;
            len  <= '0;
        end else begin
            if (inc_len)
                len <= len + 1'b1;
            if (inc_addr)
                addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: packs a byte stream into 16-bit instructions and writes instruction memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cu_hold,
    output logic              prog_done,
    output logic [ADDR_W:0]   prog_len,
    output logic              err_illegal,
    output logic              err_full
);

    LoadState state, next_state;
    logic [7:0] hi_q;
    logic       restart, illegal, is_halt, at_last;

    assign restart = start && (state == L_IDLE || state == L_DONE || state == L_ERR);
    assign illegal = in_byte[7:4] > _halt;
    assign is_halt = hi_q[7:4] == _halt;
    assign cu_hold = state != L_DONE;

    loader_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .clear    (restart),
        .inc_len  (im_we),
        .inc_addr (im_we && !is_halt && !at_last),
        .addr     (im_addr),
        .len      (prog_len),
        .at_last  (at_last)
    );

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= L_IDLE;
        else
            state <= next_state;
    end

    // Next-state and handshake/write strobes.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        im_we      = 1'b0;
        case (state)
            L_IDLE, L_DONE, L_ERR: next_state = start ? L_HI : state;
            L_HI: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = illegal ? L_ERR : L_LO;
            end
            L_LO: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = L_WRITE;
            end
            L_WRITE: begin
                im_we      = 1'b1;
                next_state = (is_halt || at_last) ? L_DONE : L_HI;
            end
            default: next_state = L_IDLE;
        endcase
    end

    // Byte capture; the packed word is held as im_wdata until the next instruction completes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_q     <= '0;
            im_wdata <= '0;
        end else begin
            if (state == L_HI && in_valid)
                hi_q <= in_byte;
            if (state == L_LO && in_valid)
                im_wdata <= {hi_q, in_byte};
        end
    end

    // Sticky session status, cleared by an accepted start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prog_done   <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else if (restart) begin
            prog_done   <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            if (state == L_HI && in_valid && illegal)
                err_illegal <= 1'b1;
            if (state == L_WRITE && is_halt)
                prog_done <= 1'b1;
            if (state == L_WRITE && !is_halt && at_last)
                err_full <= 1'b1;
        end
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer side of the instruction-memory interface that the control unit fetches from. It accepts a byte stream over a valid/ready handshake and packs each byte pair into a 16-bit instruction word. Each opcode is checked against the `inst` encoding before the word is written to consecutive instruction-memory addresses from 0. The control unit is held in Init until a Halt instruction has been written, or until memory fills.

Parameters:
ADDR_W, 4, instruction-memory address width; depth = 2**ADDR_W words
DATA_W, 16, instruction word width; fixed at 16 (two bytes)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load session at address 0
in_byte  input  8  stream byte; the high byte of each instruction comes first
in_valid  input  1  in_byte is valid
in_ready  output  1  loader accepts in_byte this cycle
im_we  output  1  instruction-memory write enable, one-cycle pulse
im_addr  output  ADDR_W  write address
im_wdata  output  16  packed instruction {hi_byte, lo_byte}
cu_hold  output  1  holds the control unit in Init while high
prog_done  output  1  load finished normally; sticky until the next start
prog_len  output  ADDR_W+1  number of words written this session
err_illegal  output  1  opcode > _halt (4'd5) was received; sticky
err_full  output  1  memory filled with no Halt written; sticky

Behaviour:
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cu_hold=1, prog_done=0, prog_len=0, err_illegal=0, err_full=0. State = L_IDLE.
- A byte transfer occurs when in_valid & in_ready are both high at a rising edge.
- FSM states: L_IDLE, L_HI, L_LO, L_WRITE, L_DONE, L_ERR.
- L_IDLE: in_ready=0. On start: go to L_HI; addr counter=0, prog_len=0, all flags cleared, cu_hold=1.
- L_HI: in_ready=1. On transfer, capture hi_byte and check opcode = hi_byte[7:4].
  - Opcode > 5: go to L_ERR, set err_illegal, no write.
  - Otherwise: go to L_LO.
- L_LO: in_ready=1. On transfer, capture lo_byte and go to L_WRITE.
- L_WRITE: in_ready=0. im_we=1 for exactly this cycle, with im_addr=counter and im_wdata={hi,lo}. prog_len increments. Next state:
  - Opcode == _halt: go to L_DONE, set prog_done.
  - Otherwise, counter == 2**ADDR_W-1: go to L_DONE, set err_full; prog_done stays 0.
  - Otherwise: counter increments, go to L_HI.
- L_DONE and L_ERR: in_ready=0. cu_hold=0 in L_DONE only; cu_hold stays 1 in L_ERR. A start pulse restarts a session, exactly as from L_IDLE.
- Latency: if the hi byte is accepted in cycle N and the lo byte in cycle N+1, im_we is high in cycle N+2. Peak throughput is one instruction per 3 cycles.
- Stalls: in_valid=0 in L_HI or L_LO holds the state indefinitely; no timeout.
- start while in L_HI, L_LO or L_WRITE is ignored.
- Reset asserted mid-session: all outputs return immediately to their reset values and the state returns to L_IDLE. Memory contents are not cleared. A partially captured instruction is discarded.
- im_wdata holds its last written value when im_we=0.
- prog_len is ADDR_W+1 bits wide so that a full memory (16 words) is representable.

Decomposition:
- The loader state enum `LoadState` (L_IDLE..L_ERR, logic [2:0]) goes in the shared StateDefs package, alongside `State` and `inst`.
- Opcode comparisons use `inst` values only (_halt and the legal range bound); no literal opcodes appear in the RTL.
- Add `loadstate_to_string` to the package for bench logging.
- One sub-module: `loader_addr_counter`. It holds the address register and the prog_len count, with clear, increment and at_last outputs.

Test Plan:
- Reset, start; stream 0x20,0x31 (Load_A), 0x30,0x12 (Add), 0x50,0x00 (Halt). Expect:
  - writes 0x2031@0, 0x3012@1, 0x5000@2, each a single im_we pulse two cycles after its hi byte;
  - prog_len=3, prog_done=1, cu_hold falls to 0.
- Stream 0x70,0xAA. Expect: err_illegal=1 on the cycle after the hi byte, no im_we, cu_hold stays 1, in_ready=0, state L_ERR.
- Stream 16 Noop words (0x00,0x00). Expect: writes at addresses 0..15, err_full=1, prog_done=0, prog_len=16, cu_hold=0.
- Drop in_valid for 5 cycles between the hi and lo bytes. Expect: state held in L_LO, no write, correct word written once lo arrives.
- Assert Reset during L_LO of the second instruction. Expect: asynchronous return to reset values. A new start then writes at address 0 and prog_len restarts at 0.
- Pulse start during L_LO. Expect: ignored. After Halt, pulse start again. Expect: flags cleared, cu_hold=1, writes resume at address 0.
